pll_reset_sequencer: RTL and testbench

//  Consumer side of the iCE40 PLL: runs on the PLL output clock and watches the PLL lock signal.

---
 rtl/pll_reset_sequencer.sv | 111 +++++++++++
 tb/tb_pll_reset_sequencer.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - PLL lock watcher that sequences the downstream reset
module pll_reset_sequencer #(
  parameter int SYNC_STAGES   = 2,
  parameter int SETTLE_CYCLES = 50000,
  parameter int HOLD_CYCLES   = 16,
  parameter int LOSS_CNT_W    = 8
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  pll_lock,
  input  logic                  force_rst,
  output logic                  rst_out_n,
  output logic                  ready,
  output logic                  lock_sync,
  output logic [1:0]            state,
  output logic [LOSS_CNT_W-1:0] loss_count
);

  localparam int MAX_CYCLES = (SETTLE_CYCLES > HOLD_CYCLES) ? SETTLE_CYCLES : HOLD_CYCLES;
  localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_LOCK = 2'd0,
    SETTLE    = 2'd1,
    HOLD      = 2'd2,
    RUN       = 2'd3
  } state_t;

  state_t                 cur_state;
  logic [CNT_W-1:0]       cnt;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  // Bring the asynchronous PLL lock into the clock domain through a flop chain.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      sync_q <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], pll_lock};
    end
  end

  assign lock_s    = sync_q[SYNC_STAGES-1];
  assign lock_sync = lock_s;
  assign state     = cur_state;

  // Sequencing FSM; reset outputs are registered and change only on RUN entry/exit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      cur_state  <= WAIT_LOCK;
      cnt        <= '0;
      rst_out_n  <= 1'b0;
      ready      <= 1'b0;
      loss_count <= '0;
    end else begin
      case (cur_state)
        WAIT_LOCK: begin
          if (lock_s && !force_rst) begin
            cur_state <= SETTLE;
            cnt       <= '0;
          end
        end
        SETTLE: begin
          if (!lock_s || force_rst) begin
            cur_state <= WAIT_LOCK;
            cnt       <= '0;
          end else if (cnt == SETTLE_LAST) begin
            cur_state <= HOLD;
            cnt       <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        HOLD: begin
          if (!lock_s || force_rst) begin
            cur_state <= WAIT_LOCK;
            cnt       <= '0;
          end else if (cnt == HOLD_LAST) begin
            cur_state <= RUN;
            cnt       <= '0;
            rst_out_n <= 1'b1;
            ready     <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RUN: begin
          if (!lock_s || force_rst) begin
            cur_state <= WAIT_LOCK;
            cnt       <= '0;
            rst_out_n <= 1'b0;
            ready     <= 1'b0;
            // Only a real lock loss is counted; a software request alone is not.
            if (!lock_s && (loss_count != {LOSS_CNT_W{1'b1}})) begin
              loss_count <= loss_count + 1'b1;
            end
          end
        end
        default: begin
          cur_state <= WAIT_LOCK;
          cnt       <= '0;
          rst_out_n <= 1'b0;
          ready     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer
module tb_pll_reset_sequencer;

  localparam int SYNC = 2;
  localparam int S    = 4;
  localparam int H    = 2;
  localparam int LW   = 2;
  localparam int LMAX = 3;

  logic          clock;
  logic          reset_n;
  logic          pll_lock;
  logic          force_rst;
  logic          rst_out_n;
  logic          ready;
  logic          lock_sync;
  logic [1:0]    state;
  logic [LW-1:0] loss_count;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: age = edges since leaving WAIT_LOCK (-1 while waiting).
  int m_age;
  int m_loss;
  int m_lq[$];

  pll_reset_sequencer #(
    .SYNC_STAGES  (SYNC),
    .SETTLE_CYCLES(S),
    .HOLD_CYCLES  (H),
    .LOSS_CNT_W   (LW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .pll_lock  (pll_lock),
    .force_rst (force_rst),
    .rst_out_n (rst_out_n),
    .ready     (ready),
    .lock_sync (lock_sync),
    .state     (state),
    .loss_count(loss_count)
  );

  // Free-running clock, period 10.
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic int m_state();
    if (m_age < 0) return 0;
    if (m_age < S) return 1;
    if (m_age < S + H) return 2;
    return 3;
  endfunction

  function automatic int m_run();
    return (m_age >= S + H) ? 1 : 0;
  endfunction

  task automatic model_reset();
    m_age  = -1;
    m_loss = 0;
    m_lq.delete();
    for (int i = 0; i < SYNC; i++) m_lq.push_back(0);
  endtask

  task automatic model_edge(input int l, input int f);
    int ls;
    int in_run;
    ls     = m_lq[0];
    in_run = m_run();
    if (m_age < 0) begin
      if (ls == 1 && f == 0) m_age = 0;
    end else if (ls == 0 || f == 1) begin
      if (in_run == 1 && ls == 0 && m_loss < LMAX) m_loss++;
      m_age = -1;
    end else if (in_run == 0) begin
      m_age++;
    end
    void'(m_lq.pop_front());
    m_lq.push_back(l);
  endtask

  task automatic chk(input string tag, input int obs, input int exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".state"}, int'(state), m_state());
    chk({tag, ".rst_out_n"}, int'(rst_out_n), m_run());
    chk({tag, ".ready"}, int'(ready), m_run());
    chk({tag, ".lock_sync"}, int'(lock_sync), m_lq[0]);
    chk({tag, ".loss_count"}, int'(loss_count), m_loss);
  endtask

  task automatic step(input string tag, input logic l, input logic f);
    pll_lock  = l;
    force_rst = f;
    @(posedge clock);
    model_edge(int'(l), int'(f));
    #1;
    check_all(tag);
  endtask

  task automatic reset_pulse();
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("rst_pulse");
    @(posedge clock);
    #1;
    reset_n = 1'b1;
  endtask

  task automatic run_to_run(input string tag);
    int n;
    n = 0;
    while (m_run() == 0 && n < 40) begin
      step(tag, 1'b1, 1'b0);
      n++;
    end
    if (m_run() == 0) chk({tag, ".timeout"}, 0, 1);
  endtask

  initial begin
    int e_settle, e_hold, e_run, e_rst, n;
    reset_n   = 1'b0;
    pll_lock  = 1'b1;
    force_rst = 1'b0;
    model_reset();

    // 1: reset held with lock high
    #1;
    check_all("t1_reset");
    for (int i = 0; i < 3; i++) begin
      @(posedge clock);
      #1;
      check_all("t1_held");
    end
    reset_n = 1'b1;

    // 2: first lock sequence, edge numbers of each state entry
    e_settle = -1; e_hold = -1; e_run = -1; e_rst = -1;
    for (int e = 1; e <= 12; e++) begin
      step("t2", 1'b1, 1'b0);
      if (e_settle < 0 && state == 2'd1) e_settle = e;
      if (e_hold < 0 && state == 2'd2) e_hold = e;
      if (e_run < 0 && state == 2'd3) e_run = e;
      if (e_rst < 0 && rst_out_n === 1'b1) e_rst = e;
    end
    chk("t2_settle_edge", e_settle, 3);
    chk("t2_hold_edge", e_hold, 7);
    chk("t2_run_edge", e_run, 9);
    chk("t2_rst_edge", e_rst, 9);

    // 3: one-cycle lock drop in SETTLE with cnt=2
    reset_pulse();
    n = 0;
    while (m_age != 2 && n < 20) begin
      step("t3_pre", 1'b1, 1'b0);
      n++;
    end
    step("t3_drop", 1'b0, 1'b0);
    n = 0;
    while (rst_out_n !== 1'b1 && n < 30) begin
      step("t3_relock", 1'b1, 1'b0);
      n++;
    end
    chk("t3_relock_edges", n, 9);
    chk("t3_loss", int'(loss_count), 0);

    // 4: repeated lock loss in RUN, counter saturates
    for (int i = 0; i < 5; i++) begin
      n = 0;
      while (rst_out_n === 1'b1 && n < 10) begin
        step("t4_drop", 1'b0, 1'b0);
        n++;
      end
      chk("t4_drop_edges", n, 3);
      chk("t4_loss", int'(loss_count), (i + 1 > LMAX) ? LMAX : i + 1);
      run_to_run("t4_relock");
    end

    // 5: force_rst pulse in RUN, then held force
    step("t5_force", 1'b1, 1'b1);
    chk("t5_rst_low", int'(rst_out_n), 0);
    n = 0;
    while (rst_out_n !== 1'b1 && n < 20) begin
      step("t5_back", 1'b1, 1'b0);
      n++;
    end
    chk("t5_back_edges", n, 7);
    chk("t5_loss", int'(loss_count), LMAX);
    for (int i = 0; i < 10; i++) step("t5_hold", 1'b1, 1'b1);
    chk("t5_held_state", int'(state), 0);
    run_to_run("t5_relock");

    // 6: asynchronous reset mid-HOLD, then simultaneous drop and force in RUN
    reset_pulse();
    n = 0;
    while (m_state() != 2 && n < 20) begin
      step("t6_pre", 1'b1, 1'b0);
      n++;
    end
    #2;
    reset_n = 1'b0;
    model_reset();
    #1;
    check_all("t6_async");
    chk("t6_async_state", int'(state), 0);
    @(posedge clock);
    #1;
    reset_n = 1'b1;
    run_to_run("t6_run");
    step("t6_d1", 1'b0, 1'b0);
    step("t6_d2", 1'b0, 1'b0);
    step("t6_both", 1'b0, 1'b1);
    chk("t6_both_loss", int'(loss_count), 1);
    chk("t6_both_state", int'(state), 0);

    // Randomized lock glitches and force requests
    reset_pulse();
    for (int i = 0; i < 400; i++) begin
      step("rand", logic'(($urandom % 10) != 0), logic'(($urandom % 25) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
